// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, flush and
// saturating stall/flush performance counters.
module if_id_skid_reg #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [63:0]            inflow,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [63:0]            outflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] stall_count,
    output logic [COUNT_WIDTH-1:0] flush_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] SKID  = 2'd2;

    logic [1:0]  state;
    logic [31:0] main_pc;
    logic [31:0] main_instr;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        accept;
    logic        drain;

    // Handshake outputs come from registered state only
    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign outflow   = {main_pc, out_valid ? main_instr : NOP_INSTR};

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) state <= FULL;
                FULL: begin
                    if (accept && !drain)
                        state <= SKID;
                    else if (!accept && drain)
                        state <= EMPTY;
                end
                SKID: if (drain) state <= FULL;
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_pc    <= 32'h0;
            main_instr <= NOP_INSTR;
            skid_pc    <= 32'h0;
            skid_instr <= NOP_INSTR;
        end else if (!flush) begin
            unique case (state)
                EMPTY: begin
                    if (accept) {main_pc, main_instr} <= inflow;
                end
                FULL: begin
                    if (accept && drain)
                        {main_pc, main_instr} <= inflow;
                    else if (accept)
                        {skid_pc, skid_instr} <= inflow;
                end
                SKID: begin
                    if (drain) begin
                        main_pc    <= skid_pc;
                        main_instr <= skid_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (out_valid && !out_ready && stall_count != '1)
                stall_count <= stall_count + COUNT_WIDTH'(1);
            if (flush && out_valid && flush_count != '1)
                flush_count <= flush_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: queue-based reference model
// of occupancy, ordering, flush and counters.
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          CW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [63:0]   inflow = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   outflow;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int            tests = 0;
    int            fails = 0;
    logic [63:0]   q[$];
    logic [CW-1:0] st_exp = '0;
    logic [CW-1:0] fl_exp = '0;

    if_id_skid_reg #(.NOP_INSTR(NOP), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .inflow(inflow), .in_valid(in_valid),
        .in_ready(in_ready), .outflow(outflow), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive, compare against model, advance model.
    task automatic cyc(input bit iv, input logic [31:0] pc,
                       input logic [31:0] ins, input bit ordy,
                       input bit fl);
        bit acc;
        bit drn;
        in_valid  = iv;
        inflow    = {pc, ins};
        out_ready = ordy;
        flush     = fl;
        #1;
        check("in_ready", {63'h0, in_ready}, {63'h0, q.size() < 2});
        check("out_valid", {63'h0, out_valid}, {63'h0, q.size() > 0});
        if (q.size() > 0)
            check("outflow", outflow, q[0]);
        else
            check("nop_instr", {32'h0, outflow[31:0]}, {32'h0, NOP});
        check("stall_count", {60'h0, stall_count}, {60'h0, st_exp});
        check("flush_count", {60'h0, flush_count}, {60'h0, fl_exp});
        acc = iv && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        if (q.size() > 0 && !ordy && st_exp != '1) st_exp++;
        if (fl && q.size() > 0 && fl_exp != '1) fl_exp++;
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back({pc, ins});
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("rst_outflow", outflow, {32'h0, NOP});
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // idle
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);

        // streaming
        cyc(1, 32'h0, 32'h0050_0093, 1, 0);
        cyc(1, 32'h4, 32'h00A0_0113, 1, 0);
        cyc(1, 32'h8, 32'h0020_81B3, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // stall with skid
        cyc(1, 32'h10, 32'h1111_0013, 1, 0);
        cyc(1, 32'h14, 32'h2222_0013, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

        // flush while in SKID with in_valid high
        cyc(1, 32'h20, 32'h3333_0013, 0, 0);
        cyc(1, 32'h24, 32'h4444_0013, 0, 0);
        cyc(1, 32'h28, 32'h5555_0013, 0, 1);
        check("flush_once", {60'h0, flush_count}, 64'h1);
        cyc(1, 32'h40, 32'h6666_0013, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // accept + drain + flush together in FULL
        cyc(1, 32'h50, 32'h7777_0013, 1, 0);
        cyc(1, 32'h54, 32'h8888_0013, 1, 1);
        cyc(0, 0, 0, 1, 0);

        // asynchronous reset while FULL
        cyc(1, 32'h60, 32'h9999_0013, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("areset_out_valid", {63'h0, out_valid}, 64'h0);
        check("areset_in_ready", {63'h0, in_ready}, 64'h1);
        check("areset_outflow", outflow, {32'h0, NOP});
        q.delete();
        st_exp = '0;
        fl_exp = '0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0, 1, 0);

        // stall counter saturation
        cyc(1, 32'h70, 32'hAAAA_0013, 0, 0);
        for (int i = 0; i < (1 << CW) + 5; i++) cyc(0, 0, 0, 0, 0);
        check("stall_sat", {60'h0, stall_count}, 64'hF);
        cyc(0, 0, 0, 1, 0);

        // random traffic
        for (int i = 0; i < 80; i++)
            cyc(1'($urandom_range(0, 1)), 32'h100 + 32'(i * 4), $urandom,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
